// File: rtl/tick_countdown_pkg.sv
// Shared definitions for the tick-driven countdown timer: state encoding and default width.
package tick_countdown_pkg;

    localparam int DEFAULT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_countdown_edge.sv
// Rising-edge detector for the incoming tick so a held-high tick is only counted once.
module tick_edge (
    input  logic clk,
    input  logic clr,
    input  logic tickIn,
    output logic tickAcc
);

    logic tickPrev_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            tickPrev_q <= 1'b0;
        end else begin
            tickPrev_q <= tickIn;
        end
    end

    assign tickAcc = tickIn & ~tickPrev_q;

endmodule

// File: rtl/tick_countdown.sv
// Programmable countdown timer: loads a start value, decrements per accepted tick,
// strobes done at terminal count, optionally reloading for periodic operation.
module tick_countdown
    import tick_countdown_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         CLKcount,
    input  logic         CLR,
    input  logic         tickIn,
    input  logic [W-1:0] loadVal,
    input  logic         start,
    input  logic         stop,
    input  logic         autoReload,
    output logic [W-1:0] countVal,
    output logic         busy,
    output logic         paused,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic         tickAcc;
    state_e       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         done_q, done_d;
    logic         busy_q, paused_q;

    tick_edge uEdge (
        .clk     (CLKcount),
        .clr     (CLR),
        .tickIn  (tickIn),
        .tickAcc (tickAcc)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && start) begin
                    if (loadVal != '0) begin
                        count_d  = loadVal;
                        reload_d = loadVal;
                        state_d  = ST_RUN;
                    end else begin
                        count_d = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // stop and start both swallow the tick of the same cycle
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (start) begin
                    if (loadVal != '0) begin
                        count_d  = loadVal;
                        reload_d = loadVal;
                    end else begin
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tickAcc) begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else begin
                        done_d = 1'b1;
                        if (autoReload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKcount) begin
        if (CLR) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= (state_d == ST_RUN);
            paused_q <= (state_d == ST_PAUSE);
        end
    end

    assign countVal = count_q;
    assign busy     = busy_q;
    assign paused   = paused_q;
    assign done     = done_q;

endmodule

// File: doc/tick_countdown.md
# tick_countdown

Programmable countdown timer that consumes the single-cycle enable ticks produced by the tick generators (1 ms / 1 s at 50 MHz). It sits downstream of a tick generator and upstream of control logic needing timed events (debounce windows, display refresh, timeouts). It loads a start value, decrements once per accepted tick, and raises a one-cycle `done` strobe at terminal count, with optional auto-reload for periodic operation.

## Interface
- `W`, default 16: counter width in bits.
- `CLKcount`  in  1  system clock, 50 MHz.
- `CLR`  in  1  synchronous, active-high reset.
- `tickIn`  in  1  tick from a tick generator; only its rising edge is counted.
- `loadVal`  in  W  start/reload value, sampled only on an accepted `start`.
- `start`  in  1  one-cycle command: load/restart, or resume from PAUSE.
- `stop`  in  1  one-cycle command: pause from RUN, abort from PAUSE.
- `autoReload`  in  1  level: reload at terminal count instead of stopping.
- `countVal`  out  W  current remaining count, registered.
- `busy`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  one-cycle strobe at terminal count.

## Operation
- Clock: one clock, `CLKcount`. Reset: `CLR`, synchronous and active-high.
- Tick acceptance: `tickAcc = tickIn & ~tickPrev`. `tickPrev` is a register reset to 0. A held-high `tickIn` counts once.
- States: IDLE, RUN, PAUSE. Reset state is IDLE.
- IDLE:
  - `start` with `loadVal != 0`: `countVal <= loadVal`, `reloadReg <= loadVal`, go to RUN.
  - `start` with `loadVal == 0`: `done` pulses 1 cycle, `countVal` stays 0, stay in IDLE.
  - `stop` is ignored.
- RUN:
  - `tickAcc` with `countVal > 1`: decrement by 1.
  - `tickAcc` with `countVal == 1`:
    - `done <= 1`.
    - If `autoReload`: `countVal <= reloadReg`, stay in RUN.
    - Otherwise: `countVal <= 0`, go to IDLE.
  - `start`: restart with the new `loadVal` (same rules as IDLE, including the zero case, which exits to IDLE). The tick in that cycle is dropped.
  - `stop`: go to PAUSE, `countVal` held. The tick in that cycle is dropped.
- PAUSE:
  - Ticks are ignored.
  - `start`: resume, go to RUN with no reload; `loadVal` is ignored.
  - `stop`: abort, `countVal <= 0`, go to IDLE, no `done`.
- Priority each cycle: `CLR` > `stop` > `start` > `tickAcc`. When `start` and `stop` are both high, `stop` wins.
- `autoReload` is sampled at the terminal tick, so it may change mid-run.
- Arithmetic: unsigned, width `W`. `countVal` never underflows: no decrement at 0, and RUN never holds 0.
- `reloadReg` is internal, width `W`, reset to 0.

## Timing
- Reset values: `countVal = 0`, `busy = 0`, `paused = 0`, `done = 0`, `tickPrev = 0`, `reloadReg = 0`, state IDLE.
- `CLR` asserted mid-operation forces the reset values at the next edge. Any pending `done` is suppressed.
- All outputs are registered. Latency is one edge from the sampled input to the visible output.
- Decrement: `countVal` updates on the same edge that first samples `tickIn` high, provided `tickPrev == 0`.
- `done` is high exactly one cycle, coincident with `countVal` taking its terminal value (0 or `reloadReg`).
- `start` at edge N: `countVal = loadVal` and `busy = 1` after edge N.
- A tick at edge N+1 decrements, so a load of L produces `done` on the L-th accepted tick after load.
- Back-to-back ticks on consecutive cycles are impossible under edge detection. The minimum tick spacing is 2 cycles.

## Structure
- Shared package / include: state encoding constants `ST_IDLE = 2'd0`, `ST_RUN = 2'd1`, `ST_PAUSE = 2'd2`, and the default `W`.
- One natural sub-module: `tick_edge`, which registers `tickPrev` and outputs `tickAcc`.
- Everything else lives in `tick_countdown`: the state register, `countVal` / `reloadReg` datapath, and output registers.

## Test plan
- Reset then basic countdown: `CLR` 1 cycle; `loadVal = 3`, `start`; three `tickIn` pulses 5 cycles apart.
  - `countVal` goes 3 → 2 → 1 → 0.
  - `done` is high only on the third tick edge.
  - `busy` drops on that same edge.
- Auto-reload: `loadVal = 2`, `autoReload = 1`, six ticks.
  - `countVal` sequence is 2, 1, 2, 1, 2, 1, 2.
  - `done` pulses on ticks 2, 4 and 6.
  - `busy` stays 1 throughout.
- Held tick and zero load:
  - `tickIn` held high 10 cycles with `countVal = 5`: exactly one decrement, to 4.
  - `start` with `loadVal = 0` in IDLE: one `done` pulse, `busy` stays 0.
- Pause/resume/abort: `loadVal = 4`, one tick (→ 3), then `stop`.
  - In PAUSE: 3 ticks leave `countVal = 3`, with `paused = 1`.
  - `start` resumes; 3 ticks give `countVal = 0` and `done`.
  - Repeat the sequence, but issue `stop` twice: `countVal = 0`, IDLE, no `done`.
- Simultaneous events:
  - `stop` with `tickAcc` at `countVal = 1`: PAUSE, `countVal = 1`, no `done`.
  - `start` and `stop` together in RUN: PAUSE.
- `CLR` mid-run at `countVal = 7`:
  - Next edge: all outputs 0, state IDLE.
  - Subsequent ticks have no effect.
